// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: the CPU always wins, a valid/ready secondary master fills idle cycles.
// Optional boot hold (macro MEM_ARBITER_BOOT_HOLD_EN) keeps the CPU off the RAM until boot_done.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int STARVE_LIM = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic          cpu_rstrb,
  input  logic [3:0]    cpu_wstrb,
  output logic [31:0]   cpu_rdata,
  input  logic          s_valid,
  input  logic [AW-1:0] s_addr,
  input  logic [31:0]   s_wdata,
  input  logic [3:0]    s_wstrb,
  output logic          s_ready,
  output logic          s_rvalid,
  output logic [31:0]   s_rdata,
  output logic          s_starve,
  input  logic          starve_clr,
`ifdef MEM_ARBITER_BOOT_HOLD_EN
  input  logic          boot_done,
  output logic          cpu_rst_n,
`endif
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_rstrb,
  output logic [3:0]    mem_wstrb,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic {IDLE, S_RD} state_t;
  typedef enum logic {OWN_CPU, OWN_SEC} owner_t;

  localparam logic [15:0] LIM = 16'(STARVE_LIM);

  state_t      state;
  owner_t      owner;
  logic        cpu_en;
  logic        cpu_act;
  logic        s_acc_rd;
  logic        waiting;
  logic        starve_set;
  logic [15:0] wait_cnt;
  logic [15:0] wait_cnt_nxt;

`ifdef MEM_ARBITER_BOOT_HOLD_EN
  // CPU stays in reset until the loader signals completion; never re-asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cpu_rst_n <= 1'b0;
    else if (boot_done)
      cpu_rst_n <= 1'b1;
  end
  assign cpu_en = cpu_rst_n;
`else
  assign cpu_en = 1'b1;
`endif

  assign cpu_act  = cpu_en & (cpu_rstrb | (|cpu_wstrb));
  assign s_ready  = s_valid & ~cpu_act;
  assign s_acc_rd = s_ready & (s_wstrb == 4'd0);

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_rstrb = 1'b0;
    mem_wstrb = 4'd0;
    if (cpu_act) begin
      mem_rstrb = cpu_rstrb;
      mem_wstrb = cpu_wstrb;
    end else if (s_valid) begin
      mem_addr  = s_addr;
      mem_wdata = s_wdata;
      mem_wstrb = s_wstrb;
      mem_rstrb = (s_wstrb == 4'd0);
    end
  end

  // RAM output is shared; the owner of the last read strobe decides who sees it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= OWN_CPU;
    end else begin
      if (mem_rstrb)
        owner <= cpu_act ? OWN_CPU : OWN_SEC;
      case (state)
        IDLE:    state <= s_acc_rd ? S_RD : IDLE;
        S_RD:    state <= s_acc_rd ? S_RD : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign s_rvalid  = (state == S_RD) & (owner == OWN_SEC);
  assign s_rdata   = mem_rdata;
  assign cpu_rdata = mem_rdata;

  assign waiting      = s_valid & ~s_ready;
  assign wait_cnt_nxt = !waiting        ? 16'd0 :
                        (wait_cnt >= LIM) ? LIM : wait_cnt + 16'd1;
  assign starve_set   = waiting & (wait_cnt_nxt == LIM);

  // A fresh set outranks a simultaneous clear so a starving master is never missed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 16'd0;
      s_starve <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      if (starve_set)
        s_starve <= 1'b1;
      else if (starve_clr)
        s_starve <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle-latency byte-strobed RAM.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic        cpu_rstrb = 1'b0;
  logic [3:0]  cpu_wstrb = '0;
  logic        s_valid = 1'b0;
  logic [31:0] s_addr = '0, s_wdata = '0, s_rdata;
  logic [3:0]  s_wstrb = '0;
  logic        s_ready, s_rvalid, s_starve;
  logic        starve_clr = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rstrb;
  logic [3:0]  mem_wstrb;
`ifdef MEM_ARBITER_BOOT_HOLD_EN
  logic        boot_done = 1'b0;
  logic        cpu_rst_n;
`endif
  logic        preload = 1'b1;
  logic [31:0] ram [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rstrb(cpu_rstrb),
    .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .s_starve(s_starve), .starve_clr(starve_clr),
`ifdef MEM_ARBITER_BOOT_HOLD_EN
    .boot_done(boot_done), .cpu_rst_n(cpu_rst_n),
`endif
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rstrb(mem_rstrb),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'd0;
      ram[0]    <= 32'h1122_3344;
      ram[1]    <= 32'hA5A5_0001;
      ram[2]    <= 32'h0BAD_F00D;
      ram[3]    <= 32'h7777_8888;
      ram[4]    <= 32'hDEAD_BEEF;
      mem_rdata <= 32'd0;
    end else begin
      if (mem_rstrb) mem_rdata <= ram[mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with RAM preload
    repeat (3) @(posedge clk);
    #2;
    check("reset_rvalid", 32'(s_rvalid), 32'd0);
    check("reset_starve", 32'(s_starve), 32'd0);
    check("reset_rstrb", 32'(mem_rstrb), 32'd0);
    check("reset_wstrb", 32'(mem_wstrb), 32'd0);
    check("reset_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    preload = 1'b0;
    rst = 1'b1;

`ifdef MEM_ARBITER_BOOT_HOLD_EN
    // Boot hold: loader owns RAM until boot_done
    @(negedge clk);
    cpu_rstrb = 1'b1; cpu_addr = 32'h0;
    s_valid = 1'b1; s_addr = 32'h10; s_wstrb = 4'd0;
    #2;
    check("boot_cpu_rst_n_low", 32'(cpu_rst_n), 32'd0);
    check("boot_sec_ready", 32'(s_ready), 32'd1);
    check("boot_sec_addr", mem_addr, 32'h10);
    tick();
    @(negedge clk);
    s_valid = 1'b0; boot_done = 1'b1;
    tick();
    check("boot_cpu_rst_n_high", 32'(cpu_rst_n), 32'd1);
    @(negedge clk);
    boot_done = 1'b0; s_valid = 1'b1;
    #2;
    check("boot_cpu_wins_ready", 32'(s_ready), 32'd0);
    check("boot_cpu_wins_addr", mem_addr, 32'h0);
    @(negedge clk);
    cpu_rstrb = 1'b0; s_valid = 1'b0;
    tick();
`endif

    // Secondary read with CPU idle
    @(negedge clk);
    s_valid = 1'b1; s_addr = 32'h10; s_wstrb = 4'd0;
    #2;
    check("rd_ready", 32'(s_ready), 32'd1);
    check("rd_mem_rstrb", 32'(mem_rstrb), 32'd1);
    check("rd_mem_addr", mem_addr, 32'h10);
    tick();
    check("rd_rvalid", 32'(s_rvalid), 32'd1);
    check("rd_rdata", s_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    s_valid = 1'b0;
    tick();
    check("rd_rvalid_drop", 32'(s_rvalid), 32'd0);

    // Collision: CPU read and secondary write in the same cycle
    @(negedge clk);
    cpu_rstrb = 1'b1; cpu_addr = 32'h0;
    s_valid = 1'b1; s_addr = 32'h20; s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF;
    #2;
    check("col_mem_addr", mem_addr, 32'h0);
    check("col_ready", 32'(s_ready), 32'd0);
    check("col_mem_wstrb", 32'(mem_wstrb), 32'd0);
    tick();
    @(negedge clk);
    cpu_rstrb = 1'b0;
    #2;
    check("col_retry_ready", 32'(s_ready), 32'd1);
    check("col_retry_wstrb", 32'(mem_wstrb), 32'hF);
    check("col_retry_addr", mem_addr, 32'h20);
    check("col_cpu_rdata", cpu_rdata, 32'h1122_3344);
    tick();
    check("col_no_rvalid", 32'(s_rvalid), 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
    check("col_ram_written", ram[8], 32'hCAFE_F00D);

    // Partial write then back-to-back reads
    @(negedge clk);
    s_valid = 1'b1; s_addr = 32'h4; s_wdata = 32'h0000_00EE; s_wstrb = 4'b0001;
    #2;
    check("pw_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_wstrb = 4'd0;
    #2;
    check("b2b_ready0", 32'(s_ready), 32'd1);
    tick();
    check("b2b_rvalid0", 32'(s_rvalid), 32'd1);
    check("b2b_rdata0", s_rdata, 32'hA5A5_00EE);
    @(negedge clk);
    s_addr = 32'h8;
    #2;
    check("b2b_ready1", 32'(s_ready), 32'd1);
    tick();
    check("b2b_rvalid1", 32'(s_rvalid), 32'd1);
    check("b2b_rdata1", s_rdata, 32'h0BAD_F00D);
    @(negedge clk);
    s_valid = 1'b0;
    tick();
    check("b2b_rvalid_drop", 32'(s_rvalid), 32'd0);

    // Starvation: CPU holds the RAM for 6 cycles
    @(negedge clk);
    cpu_rstrb = 1'b1; cpu_addr = 32'h0;
    s_valid = 1'b1; s_addr = 32'hC; s_wstrb = 4'd0;
    #2;
    check("stv_ready_blocked", 32'(s_ready), 32'd0);
    repeat (3) tick();
    check("stv_not_yet", 32'(s_starve), 32'd0);
    tick();
    check("stv_set", 32'(s_starve), 32'd1);
    repeat (2) tick();
    @(negedge clk);
    cpu_rstrb = 1'b0;
    #2;
    check("stv_grant", 32'(s_ready), 32'd1);
    tick();
    check("stv_rvalid", 32'(s_rvalid), 32'd1);
    check("stv_rdata", s_rdata, 32'h7777_8888);
    check("stv_sticky", 32'(s_starve), 32'd1);
    @(negedge clk);
    s_valid = 1'b0; starve_clr = 1'b1;
    tick();
    @(negedge clk);
    starve_clr = 1'b0;
    check("stv_cleared", 32'(s_starve), 32'd0);

    // Async reset while a secondary read is outstanding
    @(negedge clk);
    s_valid = 1'b1; s_addr = 32'h10; s_wstrb = 4'd0;
    tick();
    check("rst_mid_rvalid", 32'(s_rvalid), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_drop", 32'(s_rvalid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    cpu_rstrb = 1'b1; cpu_addr = 32'h4;
`ifdef MEM_ARBITER_BOOT_HOLD_EN
    boot_done = 1'b1;
`endif
    #2;
`ifndef MEM_ARBITER_BOOT_HOLD_EN
    check("rst_rel_cpu_rstrb", 32'(mem_rstrb), 32'd1);
    check("rst_rel_cpu_addr", mem_addr, 32'h4);
`endif
    tick();
    check("rst_rel_no_rvalid", 32'(s_rvalid), 32'd0);
`ifndef MEM_ARBITER_BOOT_HOLD_EN
    check("rst_rel_cpu_rdata", cpu_rdata, 32'hA5A5_00EE);
`endif
    @(negedge clk);
    cpu_rstrb = 1'b0;
    tick();
    check("rst_rel_idle_rvalid", 32'(s_rvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares a single-port program/data RAM (32-bit, byte write strobes, 1-cycle read latency) between the CPU core and one secondary master (UART loader / DMA).
- The CPU port has absolute priority; the core has no stall input, so its strobes always pass through unmodified.
- The secondary port uses a valid/ready request channel and a valid response channel. It is served in cycles where the CPU issues no strobe.
- Sits between cpu and the RAM wrapper in the SoC top.

Parameters:
- AW, 32, address width of all ports.
- STARVE_LIM, 64, secondary-wait cycles before the starve flag sets (1..65535).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- cpu_addr  input  AW  CPU address
- cpu_wdata  input  32  CPU write data
- cpu_rstrb  input  1  CPU read strobe
- cpu_wstrb  input  4  CPU byte write mask
- cpu_rdata  output  32  read data to CPU
- s_valid  input  1  secondary request valid
- s_addr  input  AW  secondary address
- s_wdata  input  32  secondary write data
- s_wstrb  input  4  secondary byte mask; 0 = read
- s_ready  output  1  request accepted this cycle
- s_rvalid  output  1  secondary read data valid
- s_rdata  output  32  secondary read data
- s_starve  output  1  sticky: secondary waited ≥ STARVE_LIM cycles
- starve_clr  input  1  clears s_starve
- mem_addr  output  AW  RAM address
- mem_wdata  output  32  RAM write data
- mem_rstrb  output  1  RAM read strobe
- mem_wstrb  output  4  RAM byte write mask
- mem_rdata  input  32  RAM read data (valid 1 cycle after mem_rstrb)

Behaviour:
- Reset (rst low, async): state IDLE, owner register = CPU, wait counter 0, s_starve 0, s_rvalid 0. mem_* strobes follow the CPU inputs combinationally, so they are 0 when the CPU drives 0.
- CPU active: cpu_act = cpu_rstrb | (|cpu_wstrb).
- Grant, combinational:
  - If cpu_act: mem_* = cpu_*, and s_ready = 0.
  - Else, if s_valid and the FSM is not blocked: mem_addr = s_addr, mem_wdata = s_wdata, mem_wstrb = s_wstrb, mem_rstrb = (s_wstrb == 0), s_ready = 1.
  - Else: mem_addr = cpu_addr and all strobes are 0.
- The secondary master holds s_valid and its fields stable until s_ready. Dropping s_valid before acceptance is permitted; nothing is issued.
- FSM states:
  - IDLE → S_RD on an accepted secondary read.
  - S_RD: s_rvalid = 1 and s_rdata = mem_rdata in this cycle (latency exactly 1 cycle after the s_ready cycle).
  - S_RD → S_RD if a new secondary read is accepted this cycle (back-to-back reads allowed). Otherwise S_RD → IDLE.
  - Accepted writes do not leave IDLE and produce no s_rvalid.
- cpu_rdata = mem_rdata, always combinational. The CPU samples one cycle after its strobe; a secondary access issued in that cycle does not disturb the RAM output seen by the CPU.
- Owner register: records the master of the last rstrb. s_rvalid is asserted only when owner = secondary.
- Same-cycle CPU and secondary write: the CPU write goes to RAM, s_ready = 0, and the secondary request is retried in the next free cycle.
- Wait counter:
  - Increments (saturating at STARVE_LIM) each cycle s_valid & ~s_ready.
  - Clears on s_ready or when s_valid = 0.
  - On reaching STARVE_LIM, s_starve sets. It stays set until starve_clr.
  - If starve_clr and the set condition occur in the same cycle, set wins.
- Reset mid-transfer: the outstanding secondary read is dropped and no s_rvalid is issued after reset.

Optional Feature:
- Macro: MEM_ARBITER_BOOT_HOLD_EN.
- Enabled:
  - Adds input boot_done (1) and output cpu_rst_n (1).
  - cpu_rst_n is registered, reset 0, and sets permanently on the first boot_done high after reset.
  - While cpu_rst_n = 0, CPU inputs are ignored (treated as cpu_act = 0), so the loader owns the RAM.
- Disabled: neither port exists, and the CPU is always honoured.

Test Plan:
- Secondary read, CPU idle: s_valid=1, s_addr=0x10, s_wstrb=0, RAM[0x10]=0xDEADBEEF → s_ready same cycle; s_rvalid=1 and s_rdata=0xDEADBEEF next cycle.
- Collision: cpu_rstrb=1 at 0x0 with s_valid write 0x20 in the same cycle → mem_addr=0x0 and s_ready=0. Next cycle (CPU idle) the write goes through, RAM[0x20] is updated, and cpu_rdata = RAM[0x0].
- Back-to-back secondary reads of 0x4 and 0x8 → s_ready in 2 consecutive cycles; s_rvalid high for 2 cycles with data in order.
- Starvation: STARVE_LIM=4, cpu_rstrb held high for 6 cycles with s_valid high → s_starve rises on the 4th wait cycle and stays set after the grant; starve_clr pulse → 0.
- Async reset asserted in S_RD → s_rvalid drops immediately with no response after release; CPU strobe passes through on the first cycle after release.
- With MEM_ARBITER_BOOT_HOLD_EN: cpu_rstrb=1 while boot_done=0 → the secondary is granted and cpu_rst_n=0. Pulse boot_done → cpu_rst_n=1 on the next edge and the CPU wins thereafter.
